// File: rtl/instruction_memory_pkg.sv
// Shared widths, boot-image constants and the boot_word() helper for instruction_memory.
package instruction_memory_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 64;

    localparam logic [INSTR_W-1:0] BOOT_BASE = 32'hF000_0000;
    localparam logic [INSTR_W-1:0] OOR_WORD  = 32'h0000_0000;

    function automatic logic [INSTR_W-1:0] boot_word(input int unsigned i);
        return BOOT_BASE | i[INSTR_W-1:0];
    endfunction

endpackage

// File: rtl/instruction_memory_array.sv
// Instruction storage: boot-image ROM, or (with INSTRUCTION_MEMORY_PROG_EN) a
// writable array that asynchronous reset reloads with the boot image.
module instruction_memory_array
    import instruction_memory_pkg::*;
#(
    parameter int unsigned MEM_SIZE = 16,
    parameter int unsigned IDX_W    = $clog2(MEM_SIZE)
) (
    input  logic               clk,
    input  logic               reset,
`ifdef INSTRUCTION_MEMORY_PROG_EN
    input  logic               prog_we,
    input  logic [IDX_W-1:0]   prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
`endif
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [INSTR_W-1:0] rd_data
);

    logic [INSTR_W-1:0] mem [MEM_SIZE];

`ifdef INSTRUCTION_MEMORY_PROG_EN
    // Only matters for non-power-of-two sizes, where prog_addr can exceed the array.
    localparam logic [IDX_W:0] MEM_SIZE_X = (IDX_W+1)'(MEM_SIZE);

    logic prog_in_range;
    assign prog_in_range = {1'b0, prog_addr} < MEM_SIZE_X;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < MEM_SIZE; i++) begin
                mem[i] <= boot_word(i);
            end
        end else if (prog_we && prog_in_range) begin
            mem[prog_addr] <= prog_data;
        end
    end
`else
    // clk and reset stay on the port list for drop-in compatibility only.
    logic unused_clk_reset;
    assign unused_clk_reset = clk ^ reset;

    always_comb begin
        for (int unsigned i = 0; i < MEM_SIZE; i++) begin
            mem[i] = boot_word(i);
        end
    end
`endif

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/instruction_memory.sv
// Word-addressed instruction memory with a combinational read and full 64-bit range check.
// Build with INSTRUCTION_MEMORY_PROG_EN to add the synchronous programming port.
module instruction_memory
    import instruction_memory_pkg::*;
#(
    parameter int unsigned MEM_SIZE = 16,
    parameter int unsigned IDX_W    = $clog2(MEM_SIZE)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  adr,
    output logic [INSTR_W-1:0] Instruction,
    output logic               addr_err
`ifdef INSTRUCTION_MEMORY_PROG_EN
    ,
    input  logic               prog_we,
    input  logic [IDX_W-1:0]   prog_addr,
    input  logic [INSTR_W-1:0] prog_data
`endif
);

    logic               in_range;
    logic [INSTR_W-1:0] rd_data;

    // Whole 64-bit compare: large or negative addresses never alias into the array.
    assign in_range = adr < ADDR_W'(MEM_SIZE);

    instruction_memory_array #(
        .MEM_SIZE (MEM_SIZE),
        .IDX_W    (IDX_W)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
`ifdef INSTRUCTION_MEMORY_PROG_EN
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
`endif
        .rd_idx    (adr[IDX_W-1:0]),
        .rd_data   (rd_data)
    );

    assign Instruction = in_range ? rd_data : OOR_WORD;
    assign addr_err    = ~in_range;

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory against an array model of the memory image.
// Programming-port scenarios run only when INSTRUCTION_MEMORY_PROG_EN is defined.
module tb_instruction_memory;

    localparam int unsigned SIZE = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] adr;
    logic [31:0] Instruction;
    logic        addr_err;
`ifdef INSTRUCTION_MEMORY_PROG_EN
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [31:0] prog_data;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] model [SIZE];

    always #5 clk = ~clk;

    instruction_memory #(
        .MEM_SIZE (SIZE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .adr         (adr),
        .Instruction (Instruction),
        .addr_err    (addr_err)
`ifdef INSTRUCTION_MEMORY_PROG_EN
        ,
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic model_boot();
        for (int i = 0; i < SIZE; i++) model[i] = 32'hF000_0000 + i;
    endtask

    task automatic read_check(input string tag, input logic [63:0] a);
        logic [31:0] exp_w;
        adr = a;
        #1;
        exp_w = (a < SIZE) ? model[a[3:0]] : 32'h0;
        check({tag, "_instr"}, {32'h0, Instruction}, {32'h0, exp_w});
        check({tag, "_err"}, {63'h0, addr_err}, {63'h0, a >= SIZE});
    endtask

    initial begin
        reset = 1'b1;
        adr   = '0;
`ifdef INSTRUCTION_MEMORY_PROG_EN
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
`endif
        model_boot();
        #2;
        read_check("in_reset_7", 64'd7);
        @(negedge clk);
        reset = 1'b0;

        read_check("boot_0", 64'd0);
        read_check("boot_5", 64'd5);
        read_check("boot_15", 64'd15);
        read_check("oor_16", 64'd16);
        read_check("oor_neg", 64'hFFFF_FFFF_FFFF_FFF3);

        for (int n = 0; n < 50; n++) begin
            logic [63:0] a;
            if (n % 2 == 0) a = 64'($urandom_range(0, 31));
            else            a = {$urandom, $urandom};
            read_check("rand_rd", a);
            #9;
        end

`ifdef INSTRUCTION_MEMORY_PROG_EN
        // Single write with old-before / new-after visibility.
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = 4'd3;
        prog_data = 32'h8B02_0020;
        read_check("wr_old_3", 64'd3);
        @(posedge clk);
        #1;
        prog_we  = 1'b0;
        model[3] = 32'h8B02_0020;
        read_check("wr_new_3", 64'd3);
        read_check("wr_keep_4", 64'd4);

        // Asynchronous reset between edges restores the boot word immediately.
        @(negedge clk);
        #2;
        reset = 1'b1;
        model_boot();
        read_check("rst_async_3", 64'd3);
        prog_we   = 1'b1;
        prog_addr = 4'd3;
        prog_data = 32'h1234_5678;
        @(posedge clk);
        #1;
        read_check("rst_blocks_wr", 64'd3);

        // Reset still high at the edge: write dropped.
        prog_addr = 4'd5;
        prog_data = 32'hAAAA_5555;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        prog_we = 1'b0;
        read_check("rst_edge_drop", 64'd5);

        // Reset released before the edge: write applied.
        @(negedge clk);
        reset     = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 4'd6;
        prog_data = 32'h5555_AAAA;
        @(posedge clk);
        #4;
        reset = 1'b0;
        @(posedge clk);
        #1;
        prog_we  = 1'b0;
        model[6] = 32'h5555_AAAA;
        read_check("rst_rel_wr", 64'd6);

        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            prog_we   = 1'b1;
            prog_addr = 4'($urandom_range(0, SIZE - 1));
            prog_data = $urandom;
            @(posedge clk);
            #1;
            prog_we = 1'b0;
            model[prog_addr] = prog_data;
            read_check("rand_wr", 64'(prog_addr));
        end
        for (int i = 0; i < SIZE; i++) read_check("final_img", 64'(i));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
